debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel debouncer for the keypad row inputs. It replaces single-row debouncing with a bank of `CHANNELS` identical per-channel state machines. Each channel has an input synchronizer, selectable input polarity and a programmable stability window. Each channel produces a debounced level, one-cycle press/release pulses and an optional auto-repeat. The bank sits between the raw row pins and the keypad scanner/decoder, which consumes `press_pulse` and `first_idx`.

## Interface
- `CHANNELS`, 4: number of independent inputs (≥1).
- `STABLE_CYCLES`, 60: consecutive synchronized samples required to accept a level change (≥2).
- `SYNC_STAGES`, 2: synchronizer flops per channel (≥2).
- `ACTIVE_LOW`, 0: 1 = raw input asserted when low.
- `REPEAT_CYCLES`, 0: auto-repeat period while held; 0 disables repeat.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `raw_in`  in  CHANNELS  unsynchronized inputs.
- `level_out`  out  CHANNELS  debounced level, 1 = asserted.
- `press_pulse`  out  CHANNELS  one-cycle pulse on accepted press and on each repeat.
- `release_pulse`  out  CHANNELS  one-cycle pulse on accepted release.
- `any_held`  out  1  OR of `level_out`.
- `first_idx`  out  max(1,$clog2(CHANNELS))  lowest index with `level_out` set; 0 when none.

## Operation
- Synchronizer: `SYNC_STAGES` flops. Normalized sample `s = sync_out ^ ACTIVE_LOW`. On reset, flops load the inactive raw level: 0, or 1 if `ACTIVE_LOW`.
- Per-channel FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Stability counter `cnt` width is $clog2(STABLE_CYCLES).
- IDLE:
  - s=1 → PRESS_WAIT, cnt←1.
- PRESS_WAIT:
  - s=0 → IDLE, cnt←0.
  - else cnt==STABLE_CYCLES-1 → HELD, press_pulse←1.
  - else cnt++.
- HELD:
  - s=0 → RELEASE_WAIT, cnt←1.
  - Repeat counter runs only here (see below).
- RELEASE_WAIT:
  - s=1 → HELD, no pulses.
  - else cnt==STABLE_CYCLES-1 → IDLE, release_pulse←1.
  - else cnt++.
- Acceptance needs STABLE_CYCLES consecutive equal samples, counting the sample that left IDLE/HELD. Any opposite sample aborts and returns to the prior stable state with no pulse.
- Level and pulse registers:
  - `level_out` is registered; 1 in HELD and RELEASE_WAIT.
  - Pulses are registered and high for exactly one cycle. Each pulse is coincident with the first cycle of the new `level_out` value.
- Auto-repeat (REPEAT_CYCLES>0):
  - Repeat counter `rcnt` clears on PRESS_WAIT→HELD.
  - In HELD, rcnt==REPEAT_CYCLES-1 → press_pulse←1, rcnt←0; else rcnt++.
  - rcnt is frozen in RELEASE_WAIT and resumes on glitch return to HELD. It clears on entry to IDLE.
- `any_held` and `first_idx` are combinational from registered `level_out`. Lowest index wins on simultaneous holds.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.

## Timing
- Reset: all outputs 0, FSMs IDLE, cnt/rcnt 0. Reset takes effect immediately on assertion, without waiting for a clock edge.
- Reset mid-PRESS_WAIT/RELEASE_WAIT: the operation is discarded, no pulse is emitted, and full requalification is required after deassertion.
- Latency: let raw_in be stable and set up before edge 0. The FSM first sees s=1 at edge SYNC_STAGES. `level_out` and `press_pulse` assert after edge SYNC_STAGES+STABLE_CYCLES-1 (edge 61 at defaults). Release is symmetric.
- First repeat pulse comes REPEAT_CYCLES cycles after the press pulse, then every REPEAT_CYCLES.
- Counter wrap is impossible: cnt never exceeds STABLE_CYCLES-1, rcnt never exceeds REPEAT_CYCLES-1.

## Structure
- Package `debounce_pkg`: typedef `dbnc_state_t` {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
- Sub-module `debounce_channel`: synchronizer, FSM, cnt and rcnt for one input. It is instantiated CHANNELS times via generate.
- The top level holds only the instances and the `any_held`/`first_idx` priority encoder.

## Test plan
- Clean press, defaults: raw_in[0]=1 from edge 0.
  - `level_out[0]`=1 and `press_pulse[0]`=1 after edge 61.
  - Pulse lasts exactly 1 cycle.
  - `any_held`=1, `first_idx`=0.
- Bounce: raw_in[1] high 30 cycles, low 5, then high.
  - No pulse during the bounce.
  - `level_out[1]` rises 61 edges after the final rising edge of raw_in[1].
- Release glitch on a held channel: raw low 20 cycles then high.
  - `level_out` stays 1 and no `release_pulse`.
  - Then raw low ≥70 cycles: one `release_pulse` and `level_out`=0 at edge 61 of the low run.
- Auto-repeat, REPEAT_CYCLES=100: hold 400 cycles after press.
  - `press_pulse` at press, +100, +200, +300.
  - None after release.
- Async reset mid-PRESS_WAIT (cnt≈30): `rst` pulsed between edges.
  - All outputs 0 immediately.
  - With raw held high, the press is accepted only after a full 61-edge requalification.
- ACTIVE_LOW=1: raw_in[2] and raw_in[3] driven low at the same edge.
  - Both `press_pulse` bits high in the same cycle.
  - `first_idx`=2.
  - After channel 2 releases, `first_idx`=3.

Source files
------------

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encoding and width helper for the keypad row
//               debouncer bank.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Per-channel debounce state; two bits cover the four states exactly.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbnc_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debouncer lane: input synchronizer, polarity
//               normalisation, stability FSM and optional auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 60,
    parameter int SYNC_STAGES   = 2,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = width_of(STABLE_CYCLES);
    localparam int RW = width_of(REPEAT_CYCLES);
    localparam logic [CW-1:0] c_CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] c_RCNT_MAX = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit            c_REPEAT_EN = (REPEAT_CYCLES > 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sample;
    dbnc_state_t            r_state;
    dbnc_state_t            w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [RW-1:0]          r_rcnt;
    logic [RW-1:0]          w_rcnt_nxt;
    logic                   r_level;
    logic                   w_level_nxt;
    logic                   r_press;
    logic                   w_press_nxt;
    logic                   r_release;
    logic                   w_release_nxt;

    // Synchronizer chain; reset loads the inactive raw level so no false press follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // 1 = asserted regardless of pin polarity.
    assign w_sample = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // Next-state, stability counting, repeat timing and pulse decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rcnt_nxt    = r_rcnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                // The sample that leaves IDLE counts as the first stable one.
                if (w_sample) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!w_sample) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_rcnt_nxt  = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (!w_sample) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CW'(1);
                end else if (c_REPEAT_EN) begin
                    if (r_rcnt == c_RCNT_MAX) begin
                        w_press_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + RW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                // rcnt is left untouched here so a glitch resumes the repeat phase.
                if (w_sample) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_rcnt_nxt    = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_rcnt_nxt  = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
    end

    // Registered outputs so pulses line up with the first cycle of the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : Bank of independent debounce channels for keypad rows, with
//               an any-held flag and lowest-index priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank
    import debounce_pkg::*;
#(
    parameter  int CHANNELS      = 4,
    parameter  int STABLE_CYCLES = 60,
    parameter  int SYNC_STAGES   = 2,
    parameter  bit ACTIVE_LOW    = 1'b0,
    parameter  int REPEAT_CYCLES = 0,
    localparam int IDX_W         = width_of(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_held,
    output logic [IDX_W-1:0]    first_idx
);

    logic [IDX_W-1:0] w_first_idx;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (raw_in[g]),
            .o_level   (level_out[g]),
            .o_press   (press_pulse[g]),
            .o_release (release_pulse[g])
        );
    end

    // Lowest held index wins; scanning downward lets the lowest hit overwrite the rest.
    always_comb begin
        w_first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (level_out[i]) begin
                w_first_idx = IDX_W'(i);
            end
        end
    end

    assign first_idx = w_first_idx;
    assign any_held  = |level_out;

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_bank
// Description : Self-checking bench for debounce_bank: three instances
//               (default, auto-repeat, active-low), a vector table and a
//               pulse scoreboard keyed on expected cycle numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

    localparam int NCH = 4;
    localparam int NDUT = 3;
    // A change driven before a rising edge shows up after SYNC_STAGES + STABLE_CYCLES edges.
    localparam int LAT = 2 + 60;

    logic       clk;
    logic       rst;
    logic [3:0] raw [NDUT];
    logic [3:0] lv  [NDUT];
    logic [3:0] pp  [NDUT];
    logic [3:0] rp  [NDUT];
    logic       ah  [NDUT];
    logic [1:0] fi  [NDUT];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int at;
        int d;
        int ch;
        bit is_press;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [3:0] raw;
        int         wait_n;
        logic [3:0] exp_level;
        logic       exp_any;
        logic [1:0] exp_idx;
        logic [3:0] push_p;
        logic [3:0] push_r;
    } vec_t;
    vec_t tbl [8];

    debounce_bank #(.CHANNELS(4), .STABLE_CYCLES(60), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0), .REPEAT_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .raw_in(raw[0]), .level_out(lv[0]), .press_pulse(pp[0]),
        .release_pulse(rp[0]), .any_held(ah[0]), .first_idx(fi[0]));

    debounce_bank #(.CHANNELS(4), .STABLE_CYCLES(60), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0), .REPEAT_CYCLES(100)) dut_r (
        .clk(clk), .rst(rst), .raw_in(raw[1]), .level_out(lv[1]), .press_pulse(pp[1]),
        .release_pulse(rp[1]), .any_held(ah[1]), .first_idx(fi[1]));

    debounce_bank #(.CHANNELS(4), .STABLE_CYCLES(60), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1), .REPEAT_CYCLES(0)) dut_l (
        .clk(clk), .rst(rst), .raw_in(raw[2]), .level_out(lv[2]), .press_pulse(pp[2]),
        .release_pulse(rp[2]), .any_held(ah[2]), .first_idx(fi[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mask(input int d, input logic [3:0] mask, input bit is_press, input int at);
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) sb.push_back('{at: at, d: d, ch: ch, is_press: is_press});
        end
    endtask

    // Match an observed pulse against the earliest outstanding expectation of the same kind.
    task automatic take_pulse(input int d, input int ch, input bit is_press);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].d == d && sb[i].ch == ch && sb[i].is_press == is_press) idx = i;
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected %s pulse dut%0d ch%0d: seen at cycle %0d, expected none",
                     is_press ? "press" : "release", d, ch, cyc);
        end else begin
            chk($sformatf("%s pulse dut%0d ch%0d cycle", is_press ? "press" : "release", d, ch),
                cyc, sb[idx].at);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < NDUT; d++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (pp[d][ch]) take_pulse(d, ch, 1'b1);
                    if (rp[d][ch]) take_pulse(d, ch, 1'b0);
                end
            end
        end
    end

    initial begin
        int t;
        tbl[0] = '{4'b0000,  2,      4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0001,  LAT-1,  4'b0000, 1'b0, 2'd0, 4'b0001, 4'b0000};
        tbl[2] = '{4'b0001,  1,      4'b0001, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[3] = '{4'b0001,  5,      4'b0001, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[4] = '{4'b1001,  LAT,    4'b1001, 1'b1, 2'd0, 4'b1000, 4'b0000};
        tbl[5] = '{4'b1000,  LAT-1,  4'b1001, 1'b1, 2'd0, 4'b0000, 4'b0001};
        tbl[6] = '{4'b1000,  1,      4'b1000, 1'b1, 2'd3, 4'b0000, 4'b0000};
        tbl[7] = '{4'b0000,  LAT,    4'b0000, 1'b0, 2'd0, 4'b0000, 4'b1000};

        rst    = 1'b0;
        raw[0] = 4'b0000;
        raw[1] = 4'b0000;
        raw[2] = 4'b1111;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Vector table on the default instance: reset state, press, second press, releases.
        for (int i = 0; i < 8; i++) begin
            raw[0] = tbl[i].raw;
            push_mask(0, tbl[i].push_p, 1'b1, cyc + LAT);
            push_mask(0, tbl[i].push_r, 1'b0, cyc + LAT);
            repeat (tbl[i].wait_n) @(negedge clk);
            chk($sformatf("vec%0d level", i), lv[0], tbl[i].exp_level);
            chk($sformatf("vec%0d any_held", i), ah[0], tbl[i].exp_any);
            chk($sformatf("vec%0d first_idx", i), fi[0], tbl[i].exp_idx);
        end

        // Bounce on ch1: 30 high, 5 low, then high for good.
        raw[0][1] = 1'b1;
        repeat (30) @(negedge clk);
        raw[0][1] = 1'b0;
        repeat (5) @(negedge clk);
        raw[0][1] = 1'b1;
        push_mask(0, 4'b0010, 1'b1, cyc + LAT);
        repeat (LAT-1) @(negedge clk);
        chk("bounce level before accept", lv[0], 4'b0000);
        @(negedge clk);
        chk("bounce level accepted", lv[0], 4'b0010);
        chk("bounce first_idx", fi[0], 1);
        repeat (10) @(negedge clk);

        // Release glitch: 20 low then high again must not release.
        raw[0][1] = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch level during low", lv[0], 4'b0010);
        raw[0][1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch level after return", lv[0], 4'b0010);

        // Genuine release.
        raw[0][1] = 1'b0;
        push_mask(0, 4'b0010, 1'b0, cyc + LAT);
        repeat (LAT-1) @(negedge clk);
        chk("release level before accept", lv[0], 4'b0010);
        @(negedge clk);
        chk("release level accepted", lv[0], 4'b0000);
        repeat (5) @(negedge clk);

        // Async reset while ch3 is held and ch0 is mid-qualification.
        raw[0] = 4'b1000;
        push_mask(0, 4'b1000, 1'b1, cyc + LAT);
        repeat (LAT) @(negedge clk);
        chk("pre-reset level", lv[0], 4'b1000);
        raw[0] = 4'b1001;
        repeat (32) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async reset level", lv[0], 4'b0000);
        chk("async reset any_held", ah[0], 0);
        chk("async reset first_idx", fi[0], 0);
        chk("async reset press", pp[0], 4'b0000);
        chk("async reset release", rp[0], 4'b0000);
        #1 rst = 1'b0;
        push_mask(0, 4'b1001, 1'b1, cyc + LAT);
        repeat (LAT-1) @(negedge clk);
        chk("requalify level early", lv[0], 4'b0000);
        @(negedge clk);
        chk("requalify level accepted", lv[0], 4'b1001);
        raw[0] = 4'b0000;
        push_mask(0, 4'b1001, 1'b0, cyc + LAT);
        repeat (LAT+3) @(negedge clk);
        chk("post-reset release level", lv[0], 4'b0000);

        // Auto-repeat instance: press, repeats every 100, then release before the fifth.
        raw[1] = 4'b0001;
        t = cyc + LAT;
        for (int k = 0; k < 4; k++) push_mask(1, 4'b0001, 1'b1, t + 100*k);
        repeat (LAT + 350) @(negedge clk);
        chk("repeat level held", lv[1], 4'b0001);
        raw[1] = 4'b0000;
        push_mask(1, 4'b0001, 1'b0, cyc + LAT);
        repeat (LAT + 200) @(negedge clk);
        chk("repeat level released", lv[1], 4'b0000);

        // Active-low instance: two rows pressed together.
        raw[2] = 4'b0011;
        push_mask(2, 4'b1100, 1'b1, cyc + LAT);
        repeat (LAT) @(negedge clk);
        chk("active-low level", lv[2], 4'b1100);
        chk("active-low any_held", ah[2], 1);
        chk("active-low first_idx", fi[2], 2);
        raw[2] = 4'b0111;
        push_mask(2, 4'b0100, 1'b0, cyc + LAT);
        repeat (LAT) @(negedge clk);
        chk("active-low level after ch2 release", lv[2], 4'b1000);
        chk("active-low first_idx after ch2 release", fi[2], 3);
        raw[2] = 4'b1111;
        push_mask(2, 4'b1000, 1'b0, cyc + LAT);
        repeat (LAT + 2) @(negedge clk);
        chk("active-low level idle", lv[2], 4'b0000);
        chk("active-low any_held idle", ah[2], 0);

        repeat (20) @(negedge clk);
        for (int i = 0; i < sb.size(); i++) begin
            $display("  outstanding: dut%0d ch%0d %s due at cycle %0d",
                     sb[i].d, sb[i].ch, sb[i].is_press ? "press" : "release", sb[i].at);
        end
        chk("scoreboard outstanding pulses", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
